// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC-3 memory arbiter slice.
package lc3_mem_pkg;

    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned WAIT_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-requester round-robin pick; last_owner advances only on the grant strobe.
module lc3_rr_arb2
    import lc3_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_cpu,
    input  logic req_dbg,
    input  logic grant_en,
    output logic grant_valid_c,
    output logic grant_owner_c
);

    logic last_owner;

    // On a tie the port that was not served last wins
    always_comb begin
        grant_valid_c = req_cpu | req_dbg;
        grant_owner_c = OWNER_CPU;
        if (req_cpu && req_dbg) begin
            grant_owner_c = ~last_owner;
        end else if (req_dbg) begin
            grant_owner_c = OWNER_DBG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWNER_DBG;
        end else if (grant_en && grant_valid_c) begin
            last_owner <= grant_owner_c;
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single-port LC-3 RAM between the CPU and debug ports with fixed
// wait states and a one-cycle ready pulse back to the granted port.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("lc3_mem_arbiter: WAIT_CYCLES must be >= 1");
    end

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               owner_q;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic               grant_valid_c;
    logic               grant_owner_c;
    logic               grant_en_c;

    assign grant_en_c = (state_q == ST_IDLE);

    lc3_rr_arb2 u_arb (
        .clk           (clk),
        .rst           (rst),
        .req_cpu       (cpu_req),
        .req_dbg       (dbg_req),
        .grant_en      (grant_en_c),
        .grant_valid_c (grant_valid_c),
        .grant_owner_c (grant_owner_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (grant_valid_c) state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP:   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and per-port read data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            owner_q   <= OWNER_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_valid_c) begin
                        owner_q   <= grant_owner_c;
                        lat_we    <= (grant_owner_c == OWNER_DBG) ? dbg_we : cpu_we;
                        lat_addr  <= (grant_owner_c == OWNER_DBG) ? dbg_addr : cpu_addr;
                        lat_wdata <= (grant_owner_c == OWNER_DBG) ? dbg_wdata : cpu_wdata;
                        cnt_q     <= CNT_W'(WAIT_CYCLES - 1);
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_RESP: begin
                    if (!lat_we) begin
                        if (owner_q == OWNER_DBG) dbg_rdata <= mem_rdata;
                        else                      cpu_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode only from registered state, so reset drops them at once
    assign busy      = (state_q != ST_IDLE);
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en && lat_we && (cnt_q == '0);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign owner     = owner_q;
    assign cpu_ready = (state_q == ST_DONE) && (owner_q == OWNER_CPU);
    assign dbg_ready = (state_q == ST_DONE) && (owner_q == OWNER_DBG);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: vector table plus multi-cycle sequences.
module tb_lc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dbg_ready, mem_en, mem_we, busy, owner;

    logic        cpu_req1;
    logic [15:0] cpu_addr1, cpu_rdata1, dbg_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        cpu_ready1, dbg_ready1, mem_en1, mem_we1, busy1, owner1;

    logic [15:0] ram [0:65535];
    logic        bd_we;
    logic [15:0] bd_addr, bd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req1), .cpu_we(1'b0), .cpu_addr(cpu_addr1), .cpu_wdata(16'h0000),
        .cpu_rdata(cpu_rdata1), .cpu_ready(cpu_ready1),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_rdata(dbg_rdata1), .dbg_ready(dbg_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1)
    );

    // Registered-read RAM with a back door for preloading
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Small ROM for the single-wait-state instance: only 0x0010 is populated
    always @(posedge clk) begin
        if (mem_en1) mem_rdata1 <= (mem_addr1 == 16'h0010) ? 16'h00FF : 16'hDEAD;
    end

    typedef struct {
        bit          dbg;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        int          drop_at;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issue one transaction on the main DUT and watch the memory side until ready
    task automatic run_txn(input bit dbg, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input int drop_at,
                           output int lat, output int en_cnt, output int we_cnt,
                           output int we_pos, output int bad_bus, output bit other_rdy);
        bit got;
        lat = -1; en_cnt = 0; we_cnt = 0; we_pos = 0; bad_bus = 0; other_rdy = 1'b0; got = 1'b0;
        @(negedge clk);
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (i == drop_at) begin
                if (dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
            end
            if (mem_en) begin
                en_cnt++;
                if (mem_addr !== addr || (we && mem_wdata !== wdata)) bad_bus++;
            end
            if (mem_we) begin
                we_cnt++;
                we_pos = i;
            end
            if (dbg ? cpu_ready : dbg_ready) other_rdy = 1'b1;
            if (dbg ? dbg_ready : cpu_ready) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, en_cnt, we_cnt, we_pos, bad_bus, cyc, prev, bad;
        bit other_rdy, got;
        logic [15:0] exp_cpu_rd, exp_dbg_rd;

        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        cpu_req1 = 0; cpu_addr1 = 0;
        bd_we = 0; bd_addr = 0; bd_data = 0;

        vecs[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 0};
        vecs[1] = '{1'b1, 1'b1, 16'h4000, 16'hBEEF, 16'h0000, 0};
        vecs[2] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 16'hBEEF, 0};
        vecs[3] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'h1234, 0};
        vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 0};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, 0};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC3C3, 0};
        vecs[7] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 2};

        // Reset values, with RAM preloaded while reset is held
        preload(16'h3000, 16'h1234);
        preload(16'h0000, 16'hC3C3);
        preload(16'h5000, 16'h1111);
        @(negedge clk);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 32'h0);
        chk("rst_mem", {mem_addr, mem_wdata}, 32'h0);
        chk("rst_ctl", 32'({cpu_ready, dbg_ready, mem_en, mem_we, busy, owner}), 32'h0);
        rst = 1'b1;

        exp_cpu_rd = 16'h0;
        exp_dbg_rd = 16'h0;
        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].dbg, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].drop_at,
                    lat, en_cnt, we_cnt, we_pos, bad_bus, other_rdy);
            if (!vecs[v].we) begin
                if (vecs[v].dbg) exp_dbg_rd = vecs[v].exp_rd;
                else             exp_cpu_rd = vecs[v].exp_rd;
            end
            chk($sformatf("v%0d latency", v), lat, 6);
            chk($sformatf("v%0d en_cycles", v), en_cnt, 4);
            chk($sformatf("v%0d we_cycles", v), we_cnt, vecs[v].we ? 1 : 0);
            if (vecs[v].we) chk($sformatf("v%0d we_pos", v), we_pos, 4);
            chk($sformatf("v%0d bus_stable", v), bad_bus, 0);
            chk($sformatf("v%0d other_ready", v), 32'(other_rdy), 32'h0);
            chk($sformatf("v%0d cpu_rdata", v), 32'(cpu_rdata), 32'(exp_cpu_rd));
            chk($sformatf("v%0d dbg_rdata", v), 32'(dbg_rdata), 32'(exp_dbg_rd));
            @(negedge clk);
            chk($sformatf("v%0d after_done", v), 32'({cpu_ready, dbg_ready, busy}), 32'h0);
        end

        // Continuous contention after reset alternates CPU, DBG, CPU, DBG
        do_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h4000;
        prev = 0;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                cyc++;
                if (cpu_ready || dbg_ready) got = 1'b1;
            end
            chk($sformatf("arb%0d winner", k), 32'({cpu_ready, dbg_ready}), (k % 2 == 0) ? 32'h2 : 32'h1);
            chk($sformatf("arb%0d owner", k), 32'(owner), 32'(k % 2));
            chk($sformatf("arb%0d interval", k), cyc - prev, (k == 0) ? 6 : 7);
            prev = cyc;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        chk("arb rdata", {cpu_rdata, dbg_rdata}, 32'h1234BEEF);

        // DBG request arriving mid-CPU access stays off the bus until the next IDLE
        @(negedge clk);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
        bad = 0; lat = -1; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (i == 2) begin
                dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'hFFFF;
            end
            if (mem_addr === 16'hFFFF || dbg_ready) bad++;
            if (cpu_ready) begin
                got = 1'b1;
                lat = i;
            end
        end
        cpu_req = 1'b0;
        chk("pend cpu_latency", lat, 6);
        chk("pend no_dbg_on_bus", bad, 0);
        chk("pend cpu_rdata", 32'(cpu_rdata), 32'h0000C3C3);
        lat = -1; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (i == 2) chk("pend dbg_owner", 32'({busy, owner}), 32'h3);
            if (dbg_ready) begin
                got = 1'b1;
                lat = i;
            end
        end
        dbg_req = 1'b0;
        chk("pend dbg_interval", lat, 7);
        chk("pend dbg_rdata", 32'(dbg_rdata), 32'h00005A5A);

        // Reset during ACCESS cycle 2 of a write aborts it before the strobe
        @(negedge clk);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h5000; cpu_wdata = 16'hAAAA;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort outputs", 32'({mem_en, mem_we, busy, cpu_ready, dbg_ready}), 32'h0);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("abort ram", 32'(ram[16'h5000]), 32'h00001111);
        chk("abort rdata", {cpu_rdata, dbg_rdata}, 32'h0);
        @(negedge clk);
        chk("abort idle", 32'({busy, cpu_ready, dbg_ready}), 32'h0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h4000;
        lat = -1; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (cpu_ready || dbg_ready) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk("post_rst winner", 32'({cpu_ready, dbg_ready}), 32'h2);
        chk("post_rst latency", lat, 6);
        cpu_req = 1'b0;
        dbg_req = 1'b0;

        // Single wait state instance
        @(negedge clk);
        cpu_req1 = 1'b1; cpu_addr1 = 16'h0010;
        lat = -1; en_cnt = 0; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (mem_en1) en_cnt++;
            if (mem_we1 || dbg_ready1) bad++;
            if (cpu_ready1) begin
                got = 1'b1;
                lat = i;
            end
        end
        cpu_req1 = 1'b0;
        chk("wc1 latency", lat, 3);
        chk("wc1 en_cycles", en_cnt, 1);
        chk("wc1 rdata", 32'(cpu_rdata1), 32'h000000FF);
        chk("wc1 side", {dbg_rdata1, mem_wdata1}, 32'h0);
        @(negedge clk);
        chk("wc1 idle", 32'({busy1, owner1, cpu_ready1}), 32'h0);
        chk("wc1 no_stray", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Shares the single-port LC-3 memory between two requesters: the CPU control path (MAR/MDR/MIO_EN/R.W side) and a debug/loader port used to preload programs and inspect memory. The block sequences each access with a fixed wait-state count and returns a one-cycle ready pulse, which becomes the CPU's Ready bit. It sits between the memory wrapper's MAR/MDR logic and the RAM macro.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
WAIT_CYCLES, 4, number of ACCESS cycles per transaction; must be >= 1, elaboration error otherwise

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, level, held until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address (MAR)
cpu_wdata  in  DATA_W  CPU write data (MDR)
cpu_rdata  out  DATA_W  registered read data for CPU
cpu_ready  out  1  one-cycle completion pulse (Ready bit)
dbg_req  in  1  debug request, level, held until dbg_ready
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  registered read data for debug port
dbg_ready  out  1  one-cycle completion pulse
mem_en  out  1  RAM enable
mem_we  out  1  RAM write strobe
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, registered, valid the cycle after an enabled read
busy  out  1  1 when state != IDLE
owner  out  1  0 = CPU, 1 = DBG; meaningful only while busy

Behaviour:
- Reset (rst low, async): state IDLE; last_owner = DBG, so the CPU wins the first tie. All outputs 0, including cpu_rdata and dbg_rdata.
- States: IDLE -> ACCESS -> RESP -> DONE -> IDLE.
- IDLE: if no request, stay. If one request, grant it. If both, grant the port that is not last_owner.
  - On the grant edge: latch addr, we and wdata; set owner and last_owner; cnt <= WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - mem_en = 1 every cycle; mem_addr and mem_wdata come from the latched values and stay stable.
  - mem_we = latched_we AND cnt==0, so a write strobes for exactly one cycle.
  - cnt decrements each cycle; at cnt==0, next state is RESP.
- RESP: mem_en = 0. mem_rdata is valid. On the exit edge, a read loads mem_rdata into the owner's rdata register. A write leaves both rdata registers unchanged. Next state is DONE.
- DONE: the owner's ready = 1 for exactly this cycle; requests are ignored. Next state is IDLE unconditionally.
- Latency: request sampled in IDLE cycle t0 -> ACCESS t0+1..t0+WAIT_CYCLES -> RESP -> ready at t0+WAIT_CYCLES+2. With the default, ready comes 6 cycles after t0.
- Requesters deassert req on the edge after ready, so the following IDLE cycle never re-serves the same request.
- Non-owner request during a transaction: held pending, with no effect on the memory interface. It is arbitrated in the next IDLE cycle.
- Owner drops req mid-transaction (protocol violation): the transaction completes and ready still pulses.
- Continuous contention: grants strictly alternate CPU, DBG, CPU, ...
- The non-owner's rdata and ready are never disturbed.
- Reset mid-transaction: all state clears asynchronously and mem_en/mem_we drop immediately. A write whose strobe cycle has not been reached never occurs. No ready is issued for the aborted transaction.
- All outputs are registered or decoded only from state/cnt/latched registers; there are no combinational paths from inputs to mem_*.

Decomposition:
- Package lc3_mem_pkg:
  - state encoding ST_IDLE, ST_ACCESS, ST_RESP, ST_DONE
  - OWNER_CPU = 0, OWNER_DBG = 1
  - default ADDR_W and DATA_W
- Sub-module lc3_rr_arb2: two-request round-robin pick from last_owner, combinational grant, with last_owner update on the grant strobe. Everything else stays in lc3_mem_arbiter.

Test Plan:
1. RAM[0x3000] = 0x1234; cpu_req read 0x3000 at t0 -> mem_en high t0+1..t0+4 with mem_addr = 0x3000 and mem_we = 0; cpu_ready single pulse at t0+6 with cpu_rdata = 0x1234; dbg_ready stays 0.
2. dbg write 0x4000 <- 0xBEEF at t0 -> mem_we high only at t0+4; dbg_ready at t0+6; a following CPU read of 0x4000 returns 0xBEEF, and dbg_rdata is unchanged.
3. After reset, cpu_req and dbg_req rise in the same cycle and are held with re-requests -> owner sequence 0, 1, 0, 1; each ready arrives 7 cycles after the previous one (6-cycle latency + 1 IDLE).
4. dbg_req rises during CPU ACCESS cycle 2 -> mem_addr shows no DBG address until the CPU's DONE; DBG is granted in the next IDLE cycle.
5. CPU write 0x5000 <- 0xAAAA with rst pulled low during ACCESS cycle 2 -> mem_en, mem_we, busy and ready go 0 immediately; RAM[0x5000] is unchanged. After release, a simultaneous request is won by the CPU.
6. WAIT_CYCLES = 1: read 0x0010 = 0x00FF -> one mem_en cycle; cpu_ready at t0+3 with rdata = 0x00FF.
